// File: rtl/tmds_timing_pkg.sv
// rtl/tmds_timing_pkg.sv - shared types and 640x480@60 defaults for the TMDS timing controller
package tmds_timing_pkg;

  localparam int CNT_W = 12;

  localparam int unsigned DEF_H_ACTIVE  = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;
  localparam bit          DEF_HSYNC_POL = 1'b0;
  localparam bit          DEF_VSYNC_POL = 1'b0;
  localparam int          DEF_FETCH_LAT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Inclusive window test; an empty window (hi < lo) never matches.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (32'(pos) >= lo) && (32'(pos) <= hi);
  endfunction

endpackage

// File: rtl/tmds_timing_ctrl_delay_line.sv
// rtl/tmds_timing_ctrl_delay_line.sv - fixed-depth shift register aligning control bits with fetched pixel data
module ctrl_delay_line #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VAL;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/tmds_timing_ctrl.sv
// rtl/tmds_timing_ctrl.sv - video timing generator feeding the three TMDS encoders
// Counters run on frame boundaries only; ACTIVE/HSYNC/VSYNC trail PIX_REQ by FETCH_LAT cycles.
module tmds_timing_ctrl
  import tmds_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HSYNC_POL = DEF_HSYNC_POL,
  parameter bit          VSYNC_POL = DEF_VSYNC_POL,
  parameter int          FETCH_LAT = DEF_FETCH_LAT
) (
  input  logic             i_pixel_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  output logic             o_pix_req,
  output logic [CNT_W-1:0] o_pix_x,
  output logic [CNT_W-1:0] o_pix_y,
  output logic             o_active,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_frame_start,
  output logic             o_line_start,
  output logic             o_running
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [2:0] CTRL_IDLE = {1'b0, ~HSYNC_POL, ~VSYNC_POL};

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("tmds_timing_ctrl: H_TOTAL/V_TOTAL must not exceed 4096");
  end
  if (FETCH_LAT < 1 || FETCH_LAT > 8) begin : g_bad_lat
    $error("tmds_timing_ctrl: FETCH_LAT must be in 1..8");
  end
  if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
    $error("tmds_timing_ctrl: active area must be non-empty");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_pix_req;
  logic [CNT_W-1:0] r_pix_x;
  logic [CNT_W-1:0] r_pix_y;
  logic             r_frame_start;
  logic             r_line_start;
  logic             r_running;
  logic             r_hsync;
  logic             r_vsync;

  logic             w_run;
  logic             w_act;
  logic             w_hs;
  logic             w_vs;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [2:0]       w_dly;

  assign w_run    = (r_state == ST_RUN);
  assign w_act    = w_run && in_window(r_h, 0, H_ACTIVE - 1) && in_window(r_v, 0, V_ACTIVE - 1);
  assign w_hs     = w_run && in_window(r_h, HS_FIRST, HS_LAST);
  assign w_vs     = w_run && in_window(r_v, VS_FIRST, VS_LAST);
  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);

  // ENABLE is only looked at in IDLE and on the final cycle of a frame.
  always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_h           <= '0;
      r_v           <= '0;
      r_pix_req     <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_running     <= 1'b0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_h <= '0;
          r_v <= '0;
          if (i_enable) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_h_wrap) begin
            r_h <= '0;
            if (w_v_wrap) begin
              r_v <= '0;
              if (!i_enable) r_state <= ST_IDLE;
            end else begin
              r_v <= r_v + 1'b1;
            end
          end else begin
            r_h <= r_h + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      r_pix_req     <= w_act;
      r_pix_x       <= w_act ? r_h : '0;
      r_pix_y       <= w_act ? r_v : '0;
      r_frame_start <= w_run && (r_h == '0) && (r_v == '0);
      r_line_start  <= w_act && (r_h == '0);
      r_running     <= w_run;
      r_hsync       <= w_hs ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_vs ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  ctrl_delay_line #(
    .DEPTH     (FETCH_LAT),
    .WIDTH     (3),
    .RESET_VAL (CTRL_IDLE)
  ) u_ctrl_dly (
    .i_clk   (i_pixel_clk),
    .i_rst_n (i_reset_n),
    .i_data  ({r_pix_req, r_hsync, r_vsync}),
    .o_data  (w_dly)
  );

  assign o_pix_req     = r_pix_req;
  assign o_pix_x       = r_pix_x;
  assign o_pix_y       = r_pix_y;
  assign o_frame_start = r_frame_start;
  assign o_line_start  = r_line_start;
  assign o_running     = r_running;
  assign o_active      = w_dly[2];
  assign o_hsync       = w_dly[1];
  assign o_vsync       = w_dly[0];

endmodule

// File: tb/tb_tmds_timing_ctrl.sv
// tb/tb_tmds_timing_ctrl.sv - directed bench on a shrunken 16x8 raster at three fetch latencies
module tb_tmds_timing_ctrl;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic        a_req, a_act, a_hs, a_vs, a_fs, a_ls, a_run;
  logic [11:0] a_x, a_y;
  logic        b_req, b_act, b_hs, b_vs, b_fs, b_ls, b_run;
  logic [11:0] b_x, b_y;
  logic        c_req, c_act, c_hs, c_vs, c_fs, c_ls, c_run;
  logic [11:0] c_x, c_y;

  tmds_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FETCH_LAT(2)) dut_a (
    .i_pixel_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
    .o_pix_req(a_req), .o_pix_x(a_x), .o_pix_y(a_y), .o_active(a_act),
    .o_hsync(a_hs), .o_vsync(a_vs), .o_frame_start(a_fs),
    .o_line_start(a_ls), .o_running(a_run));

  tmds_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FETCH_LAT(1)) dut_b (
    .i_pixel_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
    .o_pix_req(b_req), .o_pix_x(b_x), .o_pix_y(b_y), .o_active(b_act),
    .o_hsync(b_hs), .o_vsync(b_vs), .o_frame_start(b_fs),
    .o_line_start(b_ls), .o_running(b_run));

  tmds_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FETCH_LAT(8)) dut_c (
    .i_pixel_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
    .o_pix_req(c_req), .o_pix_x(c_x), .o_pix_y(c_y), .o_active(c_act),
    .o_hsync(c_hs), .o_vsync(c_vs), .o_frame_start(c_fs),
    .o_line_start(c_ls), .o_running(c_run));

  int n_cmp = 0;
  int n_err = 0;
  int p_end = 2 * FRAME - 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Reference raster: position p counts cycles since the first (0,0) of the run.
  function automatic bit live(int p);
    return (p >= 0) && (p <= p_end);
  endfunction
  function automatic bit m_act(int p);
    return live(p) && ((p % HT) < HA) && (((p / HT) % VT) < VA);
  endfunction
  function automatic bit m_hs(int p);
    return live(p) && ((p % HT) >= HA + HF) && ((p % HT) <= HA + HF + HS - 1);
  endfunction
  function automatic bit m_vs(int p);
    int v = (p / HT) % VT;
    return live(p) && (v >= VA + VF) && (v <= VA + VF + VS - 1);
  endfunction

  typedef struct {
    int k;
    bit req; int x; int y; bit fs; bit ls; bit act; bit hs; bit vs; bit run;
  } vec_t;
  localparam int NT = 17;
  vec_t tbl[NT];

  initial begin
    int ti;
    tbl[0]  = '{0,   0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[1]  = '{1,   1, 0, 0, 1, 1, 0, 1, 1, 1};
    tbl[2]  = '{2,   1, 1, 0, 0, 0, 0, 1, 1, 1};
    tbl[3]  = '{3,   1, 2, 0, 0, 0, 1, 1, 1, 1};
    tbl[4]  = '{9,   0, 0, 0, 0, 0, 1, 1, 1, 1};
    tbl[5]  = '{11,  0, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[6]  = '{13,  0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[7]  = '{15,  0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[8]  = '{16,  0, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[9]  = '{17,  1, 0, 1, 0, 1, 0, 1, 1, 1};
    tbl[10] = '{19,  1, 2, 1, 0, 0, 1, 1, 1, 1};
    tbl[11] = '{66,  0, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[12] = '{83,  0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[13] = '{113, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    tbl[14] = '{115, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    tbl[15] = '{129, 1, 0, 0, 1, 1, 0, 1, 1, 1};
    tbl[16] = '{131, 1, 2, 0, 0, 0, 1, 1, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs_a", {a_req, a_x, a_y, a_fs, a_ls, a_act, a_hs, a_vs, a_run},
        {1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk("rst_sync_pol1", {c_hs, c_vs}, 2'b00);

    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("idle_hold", {a_req, a_run, a_act, a_hs, a_vs}, 5'b00011);
    end

    // Two full frames; ENABLE drops mid second frame and must not cut it short.
    @(negedge clk) enable = 1'b1;
    @(posedge clk);
    ti = 0;
    for (int k = 0; k <= 300; k++) begin
      int q;
      q = k - 1;
      #1;
      if (k == 150) enable = 1'b0;
      if (ti < NT && tbl[ti].k == k) begin
        chk("tbl_req",  a_req, tbl[ti].req);
        chk("tbl_x",    a_x,   tbl[ti].x);
        chk("tbl_y",    a_y,   tbl[ti].y);
        chk("tbl_fs",   a_fs,  tbl[ti].fs);
        chk("tbl_ls",   a_ls,  tbl[ti].ls);
        chk("tbl_act",  a_act, tbl[ti].act);
        chk("tbl_hs",   a_hs,  tbl[ti].hs);
        chk("tbl_vs",   a_vs,  tbl[ti].vs);
        chk("tbl_run",  a_run, tbl[ti].run);
        ti++;
      end
      chk("a_run",  a_run, live(q));
      chk("a_req",  a_req, m_act(q));
      chk("a_x",    a_x,   m_act(q) ? (q % HT) : 0);
      chk("a_y",    a_y,   m_act(q) ? ((q / HT) % VT) : 0);
      chk("a_fs",   a_fs,  live(q) && (q % FRAME == 0));
      chk("a_ls",   a_ls,  m_act(q) && (q % HT == 0));
      chk("a_act",  a_act, m_act(q - 2));
      chk("a_hs",   a_hs,  !m_hs(q - 2));
      chk("a_vs",   a_vs,  !m_vs(q - 2));
      chk("b_act",  b_act, m_act(q - 1));
      chk("b_hs",   b_hs,  !m_hs(q - 1));
      chk("c_act",  c_act, m_act(q - 8));
      chk("c_hs",   c_hs,  m_hs(q - 8));
      chk("c_vs",   c_vs,  m_vs(q - 8));
      @(posedge clk);
    end
    chk("tbl_rows_applied", ti, NT);

    // Re-arm: FRAME_START in the second cycle after the sampling edge.
    @(negedge clk) enable = 1'b1;
    @(posedge clk); #1;
    chk("rearm_k0", {a_fs, a_run, a_req}, 3'b000);
    @(posedge clk); #1;
    chk("rearm_k1", {a_fs, a_run, a_req, a_x, a_y}, {3'b111, 12'd0, 12'd0});
    @(posedge clk); #1;
    chk("rearm_k2", {a_fs, a_req, a_x}, {2'b01, 12'd1});

    // Mid-frame async reset at output position (3,1) with the delay lines loaded.
    repeat (18) @(posedge clk);
    #1;
    chk("pre_rst_pos", {a_req, a_x, a_y}, {1'b1, 12'd3, 12'd1});
    chk("pre_rst_dly", a_act, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", {a_req, a_x, a_y, a_fs, a_ls, a_act, a_hs, a_vs, a_run},
        {1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk("async_rst_c", {c_act, c_hs, c_vs, c_run}, 4'b0000);
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("post_rst_a", {a_req, a_run, a_act, a_hs, a_vs}, 5'b00011);
      chk("post_rst_c", {c_req, c_run, c_act, c_hs, c_vs}, 5'b00000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
